ultrasonic_echo_responder: RTL and testbench

Synthesizable HC-SR04-style ultrasonic sensor model: answers a trigger pulse with an echo pulse whose width encodes a programmed distance. It is the responder end of the trig/echo protocol driven by our distance-sensor controller. It allows closed-loop on-board or in-bench testing of the controller and seven-segment path without a physical sensor, and it matches the controller's 9-bit centimetre distance range.

---
 rtl/ultrasonic_pkg.sv | 41 ++++
 rtl/ultrasonic_us_tick.sv | 39 +++
 rtl/ultrasonic_echo_responder.sv | 181 ++++++++++++++++++
 tb/tb_ultrasonic_echo_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic echo responder.
// Holds the FSM state encoding, default timing and the echo-width helper.
package ultrasonic_pkg;

    localparam int DIST_W = 9;
    localparam int US_W   = 16;

    localparam int unsigned DEF_CLK_MHZ     = 50;
    localparam int unsigned DEF_TRIG_MIN_US = 10;
    localparam int unsigned DEF_BURST_US    = 200;
    localparam int unsigned DEF_US_PER_CM   = 58;
    localparam int unsigned DEF_MAX_CM      = 400;
    localparam int unsigned DEF_TIMEOUT_US  = 38000;
    localparam int unsigned DEF_HOLDOFF_US  = 10000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRIG  = 3'd1,
        DELAY = 3'd2,
        ECHO  = 3'd3,
        HOLD  = 3'd4
    } state_e;

    // Out-of-range or zero distance reports the "no object" width.
    function automatic logic [US_W-1:0] echo_width_us(
        input logic [DIST_W-1:0] d,
        input int unsigned       us_per_cm,
        input int unsigned       max_cm,
        input int unsigned       timeout_us
    );
        int unsigned dd;
        int unsigned prod;
        dd   = {{(32-DIST_W){1'b0}}, d};
        prod = dd * us_per_cm;
        if (dd == 0 || dd > max_cm) begin
            return US_W'(timeout_us);
        end
        return US_W'(prod);
    endfunction

endpackage

// File: rtl/ultrasonic_us_tick.sv
// Restartable microsecond prescaler.
// tick is high on the last clock of every CLK_MHZ-cycle window.
module ultrasonic_us_tick
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_MHZ = DEF_CLK_MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_MHZ - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Wrap at the end of each microsecond, or realign on restart.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04-style responder: a valid trig pulse yields a delayed echo
// whose width encodes the distance latched at the trig fall.
module ultrasonic_echo_responder
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_MHZ     = DEF_CLK_MHZ,
    parameter int unsigned TRIG_MIN_US = DEF_TRIG_MIN_US,
    parameter int unsigned BURST_US    = DEF_BURST_US,
    parameter int unsigned US_PER_CM   = DEF_US_PER_CM,
    parameter int unsigned MAX_CM      = DEF_MAX_CM,
    parameter int unsigned TIMEOUT_US  = DEF_TIMEOUT_US,
    parameter int unsigned HOLDOFF_US  = DEF_HOLDOFF_US
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [DIST_W-1:0] distance,
    output logic              echo,
    output logic              busy,
    output logic              short_trig,
    output logic              ignored_trig
);

    localparam logic [US_W:0] TMIN = (US_W+1)'(TRIG_MIN_US);
    localparam logic [US_W:0] TBRS = (US_W+1)'(BURST_US);
    localparam logic [US_W:0] THLD = (US_W+1)'(HOLDOFF_US);

    logic trig_s1_q;
    logic trig_s2_q;
    logic trig_prev_q;
    logic rise;
    logic fall;

    state_e state_q;
    state_e state_d;

    logic [US_W-1:0]   us_q;
    logic [US_W-1:0]   us_d;
    logic [US_W:0]     us_now;
    logic [US_W:0]     us_p1;
    logic [US_W:0]     width_us;
    logic [DIST_W-1:0] dist_q;
    logic [DIST_W-1:0] dist_d;

    logic echo_q;
    logic echo_d;
    logic busy_q;
    logic busy_d;
    logic short_q;
    logic short_d;
    logic ign_q;
    logic ign_d;

    logic tick;
    logic restart;

    assign rise = trig_s2_q & ~trig_prev_q;
    assign fall = ~trig_s2_q & trig_prev_q;

    assign restart = (state_d != state_q);

    // us_now counts the microsecond completing in this cycle.
    assign us_now   = {1'b0, us_q} + {{US_W{1'b0}}, tick};
    assign us_p1    = {1'b0, us_q} + 17'd1;
    assign width_us = {1'b0, echo_width_us(dist_q, US_PER_CM,
                                           MAX_CM, TIMEOUT_US)};

    assign echo         = echo_q;
    assign busy         = busy_q;
    assign short_trig   = short_q;
    assign ignored_trig = ign_q;

    ultrasonic_us_tick #(
        .CLK_MHZ (CLK_MHZ)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Trig synchronizer and edge register; reset high so a held
    // trig at reset release does not look like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_q   <= 1'b1;
            trig_s2_q   <= 1'b1;
            trig_prev_q <= 1'b1;
        end else begin
            trig_s1_q   <= trig;
            trig_s2_q   <= trig_s1_q;
            trig_prev_q <= trig_s2_q;
        end
    end

    // Next state, distance latch and one-cycle status pulses.
    always_comb begin
        state_d = state_q;
        dist_d  = dist_q;
        short_d = 1'b0;
        ign_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (fall) begin
                    if (us_now >= TMIN) begin
                        state_d = DELAY;
                        dist_d  = distance;
                    end else begin
                        state_d = IDLE;
                        short_d = 1'b1;
                    end
                end
            end
            DELAY: begin
                ign_d = rise;
                if (tick && us_p1 >= TBRS) begin
                    state_d = ECHO;
                end
            end
            ECHO: begin
                ign_d = rise;
                if (tick && us_p1 >= width_us) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                ign_d = rise;
                if (tick && us_p1 >= THLD) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Microsecond counter: clears on entry, saturates at all-ones.
    always_comb begin
        us_d = us_q;
        if (restart) begin
            us_d = '0;
        end else if (tick && us_q != '1) begin
            us_d = us_q + US_W'(1);
        end
    end

    // Outputs registered from the next state.
    always_comb begin
        echo_d = (state_d == ECHO);
        busy_d = (state_d == DELAY) || (state_d == ECHO) ||
                 (state_d == HOLD);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            us_q    <= '0;
            dist_q  <= '0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            us_q    <= us_d;
            dist_q  <= dist_d;
            echo_q  <= echo_d;
            busy_q  <= busy_d;
            short_q <= short_d;
            ign_q   <= ign_d;
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for ultrasonic_echo_responder with scaled timing.
// Edge counts are taken at posedge+1 relative to the trig drop.
module tb_ultrasonic_echo_responder;

    localparam int CLK   = 2;
    localparam int TMIN  = 10;
    localparam int BURST = 20;
    localparam int UPC   = 7;
    localparam int MAXCM = 400;
    localparam int TOUT  = 3000;
    localparam int HOLD  = 40;

    // trig drop -> s1 low at k1, s2 low at k2, state update at k3
    localparam int BUSY_K = 3;
    localparam int RISE_K = BURST * CLK + 3;
    localparam int HOLD_C = HOLD * CLK;
    localparam int BOUND  = 20000;

    logic       clk;
    logic       rst_n;
    logic       trig;
    logic [8:0] distance;
    logic       echo;
    logic       busy;
    logic       short_trig;
    logic       ignored_trig;

    int vectors;
    int miscompares;

    ultrasonic_echo_responder #(
        .CLK_MHZ     (CLK),
        .TRIG_MIN_US (TMIN),
        .BURST_US    (BURST),
        .US_PER_CM   (UPC),
        .MAX_CM      (MAXCM),
        .TIMEOUT_US  (TOUT),
        .HOLDOFF_US  (HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig         (trig),
        .distance     (distance),
        .echo         (echo),
        .busy         (busy),
        .short_trig   (short_trig),
        .ignored_trig (ignored_trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_trig(input int tc);
        @(negedge clk);
        trig = 1'b1;
        repeat (tc) @(negedge clk);
        trig = 1'b0;
    endtask

    // Runs one trig/echo cycle and measures it; no checking here.
    task automatic run_echo(
        input  int         tc,
        input  int         ign_e,
        input  int         ign_h,
        input  int         chg_w,
        input  logic [8:0] chg_d,
        output int         rise_k,
        output int         busy_k,
        output int         width,
        output int         hold,
        output int         ign_n
    );
        rise_k = -1;
        busy_k = -1;
        width  = -1;
        hold   = -1;
        ign_n  = 0;
        drive_trig(tc);
        for (int k = 1; k <= BOUND; k++) begin
            @(posedge clk); #1;
            if (ignored_trig) ign_n++;
            if (busy && busy_k < 0) busy_k = k;
            if (echo) begin
                rise_k = k;
                break;
            end
        end
        if (rise_k > 0) begin
            for (int w = 1; w <= BOUND; w++) begin
                @(posedge clk); #1;
                if (ignored_trig) ign_n++;
                if (w == ign_e) trig = 1'b1;
                if (w == ign_e + 6) trig = 1'b0;
                if (w == chg_w) distance = chg_d;
                if (!echo) begin
                    width = w;
                    break;
                end
            end
        end
        if (width > 0) begin
            for (int h = 1; h <= BOUND; h++) begin
                @(posedge clk); #1;
                if (ignored_trig) ign_n++;
                if (h == ign_h) trig = 1'b1;
                if (h == ign_h + 6) trig = 1'b0;
                if (!busy) begin
                    hold = h;
                    break;
                end
            end
        end
        trig = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        trig     = 1'b0;
        distance = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({echo, busy, short_trig, ignored_trig} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outs: got %b expected 0000",
                     {echo, busy, short_trig, ignored_trig});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ({echo, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset: got %b expected 00", {echo, busy});
        end
    endtask

    task automatic test_main();
        int rk, bk, w, h, ig;
        distance = 9'd100;
        run_echo(24, 0, 0, 0, 9'd0, rk, bk, w, h, ig);
        vectors++;
        if (rk !== RISE_K) begin
            miscompares++;
            $display("FAIL main_rise: got %0d expected %0d", rk, RISE_K);
        end
        vectors++;
        if (bk !== BUSY_K) begin
            miscompares++;
            $display("FAIL main_busy: got %0d expected %0d", bk, BUSY_K);
        end
        vectors++;
        if (w !== 100 * UPC * CLK) begin
            miscompares++;
            $display("FAIL main_width: got %0d expected %0d",
                     w, 100 * UPC * CLK);
        end
        vectors++;
        if (h !== HOLD_C) begin
            miscompares++;
            $display("FAIL main_hold: got %0d expected %0d", h, HOLD_C);
        end
        vectors++;
        if (ig !== 0) begin
            miscompares++;
            $display("FAIL main_ign: got %0d expected 0", ig);
        end
    endtask

    task automatic test_short_trig();
        int n_short, short_k, bad;
        int rk, bk, w, h, ig;
        n_short  = 0;
        short_k  = -1;
        bad      = 0;
        distance = 9'd77;
        drive_trig(TMIN * CLK - 1);
        for (int k = 1; k <= BURST * CLK + 20; k++) begin
            @(posedge clk); #1;
            if (short_trig) begin
                n_short++;
                if (short_k < 0) short_k = k;
            end
            if (echo || busy) bad++;
        end
        vectors++;
        if (n_short !== 1) begin
            miscompares++;
            $display("FAIL short_count: got %0d expected 1", n_short);
        end
        vectors++;
        if (short_k !== BUSY_K) begin
            miscompares++;
            $display("FAIL short_at: got %0d expected %0d",
                     short_k, BUSY_K);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL short_quiet: got %0d expected 0", bad);
        end
        run_echo(TMIN * CLK, 0, 0, 0, 9'd0, rk, bk, w, h, ig);
        vectors++;
        if (rk !== RISE_K || w !== 77 * UPC * CLK) begin
            miscompares++;
            $display("FAIL min_trig: got rise %0d width %0d expected %0d %0d",
                     rk, w, RISE_K, 77 * UPC * CLK);
        end
    endtask

    task automatic test_range();
        int rk, bk, w, h, ig;
        int dv [5] = '{0, 450, 400, 401, 1};
        int ex [5];
        ex = '{TOUT * CLK, TOUT * CLK, 400 * UPC * CLK,
               TOUT * CLK, UPC * CLK};
        for (int i = 0; i < 5; i++) begin
            distance = 9'(dv[i]);
            run_echo(TMIN * CLK, 0, 0, 0, 9'd0, rk, bk, w, h, ig);
            vectors++;
            if (w !== ex[i]) begin
                miscompares++;
                $display("FAIL range_d%0d: got %0d expected %0d",
                         dv[i], w, ex[i]);
            end
        end
    endtask

    task automatic test_ignored();
        int rk, bk, w, h, ig, bad;
        distance = 9'd100;
        run_echo(TMIN * CLK, 50, 10, 0, 9'd0, rk, bk, w, h, ig);
        vectors++;
        if (ig !== 2) begin
            miscompares++;
            $display("FAIL ign_count: got %0d expected 2", ig);
        end
        vectors++;
        if (w !== 100 * UPC * CLK || h !== HOLD_C) begin
            miscompares++;
            $display("FAIL ign_timing: got %0d/%0d expected %0d/%0d",
                     w, h, 100 * UPC * CLK, HOLD_C);
        end
        bad = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (echo || busy) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL ign_no_extra: got %0d expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int rk, bk, w, h, ig, bad, seen;
        distance = 9'd50;
        seen     = 0;
        drive_trig(TMIN * CLK);
        for (int k = 0; k < BOUND; k++) begin
            @(posedge clk); #1;
            if (echo) begin
                seen = 1;
                break;
            end
        end
        vectors++;
        if (seen !== 1) begin
            miscompares++;
            $display("FAIL rst_mid_echo: got %0d expected 1", seen);
        end
        repeat (100 * CLK) @(posedge clk);
        #1;
        rst_n = 1'b0;
        trig  = 1'b1;
        #1;
        vectors++;
        if ({echo, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_clear: got %b expected 00",
                     {echo, busy});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (echo || busy || short_trig || ignored_trig) bad++;
        end
        trig = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (echo || busy || short_trig || ignored_trig) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL rst_held_trig: got %0d expected 0", bad);
        end
        run_echo(TMIN * CLK, 0, 0, 0, 9'd0, rk, bk, w, h, ig);
        vectors++;
        if (w !== 50 * UPC * CLK) begin
            miscompares++;
            $display("FAIL rst_retrig: got %0d expected %0d",
                     w, 50 * UPC * CLK);
        end
    endtask

    task automatic test_distance_change();
        int rk, bk, w, h, ig;
        distance = 9'd100;
        run_echo(TMIN * CLK, 0, 0, 100, 9'd20, rk, bk, w, h, ig);
        vectors++;
        if (w !== 100 * UPC * CLK) begin
            miscompares++;
            $display("FAIL chg_current: got %0d expected %0d",
                     w, 100 * UPC * CLK);
        end
        run_echo(TMIN * CLK, 0, 0, 0, 9'd0, rk, bk, w, h, ig);
        vectors++;
        if (w !== 20 * UPC * CLK) begin
            miscompares++;
            $display("FAIL chg_next: got %0d expected %0d",
                     w, 20 * UPC * CLK);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_main();
        test_short_trig();
        test_range();
        test_ignored();
        test_reset_mid();
        test_distance_change();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
